// File: rtl/core_boot_sequencer_if.sv
//------------------------------------------------------------------------------
// core_boot_sequencer_if : valid/ready program-image stream (header + words)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface core_boot_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

`default_nettype wire

// File: rtl/core_boot_sequencer.sv
//------------------------------------------------------------------------------
// core_boot_sequencer : loads a program image into imem, then resets/starts/watches the core
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module core_boot_sequencer #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int MAX_WORDS    = 4096,
  parameter int RESET_CYCLES = 2,
  parameter int RUN_LIMIT    = 0
) (
  input  wire logic                    clock_i,
  input  wire logic                    reset_i,
  core_boot_sequencer_if.slave         s_if,
  output logic                         imem_we_o,
  output logic [ADDRESS_BITS-1:0]      imem_addr_o,
  output logic [DATA_WIDTH-1:0]        imem_wdata_o,
  output logic                         core_reset_o,
  output logic                         start_o,
  output logic [ADDRESS_BITS-1:0]      prog_address_o,
  input  wire logic                    core_halt_i,
  output logic                         report_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         overflow_o,
  output logic                         timeout_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int WCW = $clog2(MAX_WORDS + 1);

  logic [2:0]              state_q, state_d;
  logic [ADDRESS_BITS-1:0] base_q, base_d;
  logic [WCW-1:0]          word_cnt_q, word_cnt_d;
  logic [31:0]             hold_cnt_q, hold_cnt_d;
  logic [31:0]             run_cnt_q, run_cnt_d;
  logic                    we_q, we_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [ADDRESS_BITS-1:0] prog_q, prog_d;
  logic                    report_q, report_d;
  logic                    overflow_q, overflow_d;
  logic                    timeout_q, timeout_d;
  logic                    in_ready_q, core_reset_q, start_q, busy_q, done_q;

  logic                    w_accept;
  logic [ADDRESS_BITS-1:0] w_offset;
  logic                    w_limit_hit;

  assign w_accept    = s_if.in_valid & in_ready_q;
  // Address arithmetic deliberately wraps modulo 2^ADDRESS_BITS.
  assign w_offset    = ADDRESS_BITS'({word_cnt_q, 2'b00});
  assign w_limit_hit = (RUN_LIMIT != 0) && (run_cnt_q == 32'(RUN_LIMIT - 1));

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    word_cnt_d = word_cnt_q;
    hold_cnt_d = hold_cnt_q;
    run_cnt_d  = run_cnt_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    prog_d     = prog_q;
    report_d   = 1'b0;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          base_d     = {s_if.in_data[ADDRESS_BITS-1:2], 2'b00};
          word_cnt_d = '0;
          hold_cnt_d = '0;
          overflow_d = 1'b0;
          timeout_d  = 1'b0;
          state_d    = s_if.in_last ? S_HOLD : S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          if (word_cnt_q == WCW'(MAX_WORDS)) begin
            overflow_d = 1'b1;
          end else begin
            we_d       = 1'b1;
            addr_d     = base_q + w_offset;
            wdata_d    = s_if.in_data;
            word_cnt_d = word_cnt_q + 1'b1;
          end
          if (s_if.in_last) begin
            hold_cnt_d = '0;
            state_d    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == 32'(RESET_CYCLES - 1)) begin
          prog_d    = base_q;
          run_cnt_d = '0;
          state_d   = S_START;
        end else begin
          hold_cnt_d = hold_cnt_q + 32'd1;
        end
      end
      // run_cnt counts cycles since start, so the core gets RUN_LIMIT unreset cycles.
      S_START: begin
        run_cnt_d = run_cnt_q + 32'd1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        run_cnt_d = run_cnt_q + 32'd1;
        if (core_halt_i) begin
          report_d = 1'b1;
          state_d  = S_DONE;
        end else if (w_limit_hit) begin
          report_d  = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      word_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      run_cnt_q    <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      prog_q       <= '0;
      report_q     <= 1'b0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
      in_ready_q   <= 1'b0;
      core_reset_q <= 1'b1;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      word_cnt_q   <= word_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      run_cnt_q    <= run_cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      prog_q       <= prog_d;
      report_q     <= report_d;
      overflow_q   <= overflow_d;
      timeout_q    <= timeout_d;
      in_ready_q   <= (state_d == S_IDLE) || (state_d == S_LOAD) || (state_d == S_DONE);
      core_reset_q <= !((state_d == S_START) || (state_d == S_RUN));
      start_q      <= (state_d == S_START);
      busy_q       <= (state_d == S_LOAD) || (state_d == S_HOLD) ||
                      (state_d == S_START) || (state_d == S_RUN);
      done_q       <= (state_d == S_DONE);
    end
  end

  assign s_if.in_ready  = in_ready_q;
  assign imem_we_o      = we_q;
  assign imem_addr_o    = addr_q;
  assign imem_wdata_o   = wdata_q;
  assign core_reset_o   = core_reset_q;
  assign start_o        = start_q;
  assign prog_address_o = prog_q;
  assign report_o       = report_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign overflow_o     = overflow_q;
  assign timeout_o      = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_core_boot_sequencer.sv
//------------------------------------------------------------------------------
// tb_core_boot_sequencer : directed self-checking bench for core_boot_sequencer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_core_boot_sequencer;

  logic        clk;
  logic        rst;
  logic        imem_we;
  logic [19:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        start;
  logic [19:0] prog_address;
  logic        core_halt;
  logic        report;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        timeout;

  int n_tests = 0;
  int n_fail  = 0;

  core_boot_sequencer_if #(.DATA_WIDTH(32)) sif ();

  core_boot_sequencer #(
    .DATA_WIDTH   (32),
    .ADDRESS_BITS (20),
    .MAX_WORDS    (4),
    .RESET_CYCLES (2),
    .RUN_LIMIT    (10)
  ) dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .s_if           (sif),
    .imem_we_o      (imem_we),
    .imem_addr_o    (imem_addr),
    .imem_wdata_o   (imem_wdata),
    .core_reset_o   (core_reset),
    .start_o        (start),
    .prog_address_o (prog_address),
    .core_halt_i    (core_halt),
    .report_o       (report),
    .busy_o         (busy),
    .done_o         (done),
    .overflow_o     (overflow),
    .timeout_o      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    sif.in_valid = v;
    sif.in_data  = d;
    sif.in_last  = l;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (start !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("start_seen", 32'(start), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    check({tag, "_in_ready"},   32'(sif.in_ready), 32'd0);
    check({tag, "_start"},      32'(start), 32'd0);
    check({tag, "_report"},     32'(report), 32'd0);
    check({tag, "_we"},         32'(imem_we), 32'd0);
    check({tag, "_addr"},       32'(imem_addr), 32'd0);
    check({tag, "_wdata"},      imem_wdata, 32'd0);
    check({tag, "_prog"},       32'(prog_address), 32'd0);
    check({tag, "_busy"},       32'(busy), 32'd0);
    check({tag, "_done"},       32'(done), 32'd0);
    check({tag, "_overflow"},   32'(overflow), 32'd0);
    check({tag, "_timeout"},    32'(timeout), 32'd0);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    core_halt = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    step();
    step();
    check_reset_outputs("rst");
    rst = 1'b0;
    step();
    check("idle_in_ready", 32'(sif.in_ready), 32'd1);

    // T1: header 0x100, three back-to-back words
    drive(1'b1, 32'h0000_0100, 1'b0);
    step();
    check("t1_hdr_busy", 32'(busy), 32'd1);
    check("t1_hdr_no_we", 32'(imem_we), 32'd0);
    drive(1'b1, 32'hAAAA_0001, 1'b0);
    step();
    check("t1_w0_we", 32'(imem_we), 32'd1);
    check("t1_w0_addr", 32'(imem_addr), 32'h100);
    check("t1_w0_data", imem_wdata, 32'hAAAA_0001);
    drive(1'b1, 32'hBBBB_0002, 1'b0);
    step();
    check("t1_w1_we", 32'(imem_we), 32'd1);
    check("t1_w1_addr", 32'(imem_addr), 32'h104);
    check("t1_w1_data", imem_wdata, 32'hBBBB_0002);
    drive(1'b1, 32'hCCCC_0003, 1'b1);
    step();
    check("t1_w2_we", 32'(imem_we), 32'd1);
    check("t1_w2_addr", 32'(imem_addr), 32'h108);
    check("t1_w2_data", imem_wdata, 32'hCCCC_0003);
    check("t1_hold1_ready", 32'(sif.in_ready), 32'd0);
    check("t1_hold1_creset", 32'(core_reset), 32'd1);
    check("t1_hold1_start", 32'(start), 32'd0);
    drive(1'b0, 32'h0, 1'b0);
    step();
    check("t1_hold2_we", 32'(imem_we), 32'd0);
    check("t1_hold2_creset", 32'(core_reset), 32'd1);
    check("t1_hold2_start", 32'(start), 32'd0);
    step();
    check("t1_start", 32'(start), 32'd1);
    check("t1_start_creset", 32'(core_reset), 32'd0);
    check("t1_prog", 32'(prog_address), 32'h100);
    step();
    check("t1_run_start", 32'(start), 32'd0);
    check("t1_run_creset", 32'(core_reset), 32'd0);
    core_halt = 1'b1;
    step();
    core_halt = 1'b0;
    check("t1_report", 32'(report), 32'd1);
    check("t1_done", 32'(done), 32'd1);
    check("t1_timeout", 32'(timeout), 32'd0);
    check("t1_done_creset", 32'(core_reset), 32'd1);
    step();
    check("t1_report_pulse", 32'(report), 32'd0);
    check("t1_done_ready", 32'(sif.in_ready), 32'd1);

    // T2: toggling valid; T4: run ends on the 10-cycle budget
    drive(1'b1, 32'h0000_0200, 1'b0);
    step();
    check("t2_done_cleared", 32'(done), 32'd0);
    drive(1'b0, 32'hDEAD_BEEF, 1'b0);
    step();
    check("t2_gap0_we", 32'(imem_we), 32'd0);
    drive(1'b1, 32'h1111_0000, 1'b0);
    step();
    check("t2_w0_we", 32'(imem_we), 32'd1);
    check("t2_w0_addr", 32'(imem_addr), 32'h200);
    check("t2_w0_data", imem_wdata, 32'h1111_0000);
    drive(1'b0, 32'hDEAD_BEEF, 1'b1);
    step();
    check("t2_gap1_we", 32'(imem_we), 32'd0);
    check("t2_gap1_busy", 32'(busy), 32'd1);
    drive(1'b1, 32'h2222_0001, 1'b1);
    step();
    check("t2_w1_addr", 32'(imem_addr), 32'h204);
    check("t2_w1_data", imem_wdata, 32'h2222_0001);
    drive(1'b0, 32'h0, 1'b0);
    wait_start();
    check("t2_prog", 32'(prog_address), 32'h200);
    n = 0;
    do begin
      step();
      n++;
    end while (report !== 1'b1 && n < 30);
    check("t4_report_delay", 32'(n), 32'd10);
    check("t4_timeout", 32'(timeout), 32'd1);
    check("t4_done", 32'(done), 32'd1);
    check("t4_creset", 32'(core_reset), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    step();
    check("t4_report_pulse", 32'(report), 32'd0);
    check("t4_timeout_sticky", 32'(timeout), 32'd1);

    // T3: 6-word image into a 4-word limit; then halt and budget coincide
    drive(1'b1, 32'h0000_0300, 1'b0);
    step();
    check("t3_timeout_cleared", 32'(timeout), 32'd0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h3000_0000 + 32'(i), (i == 5));
      step();
      if (i < 4) begin
        check("t3_we", 32'(imem_we), 32'd1);
        check("t3_addr", 32'(imem_addr), 32'h300 + 32'(4 * i));
        check("t3_data", imem_wdata, 32'h3000_0000 + 32'(i));
        check("t3_no_ovf_yet", 32'(overflow), 32'd0);
      end else begin
        check("t3_drop_we", 32'(imem_we), 32'd0);
        check("t3_overflow", 32'(overflow), 32'd1);
      end
      check("t3_in_ready", 32'(sif.in_ready), (i < 5) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 32'h0, 1'b0);
    wait_start();
    check("t3_prog", 32'(prog_address), 32'h300);
    for (int i = 0; i < 9; i++) step();
    check("t3_no_early_report", 32'(report), 32'd0);
    core_halt = 1'b1;
    step();
    core_halt = 1'b0;
    check("t3_both_report", 32'(report), 32'd1);
    check("t3_both_timeout", 32'(timeout), 32'd0);
    check("t3_both_done", 32'(done), 32'd1);
    check("t3_overflow_sticky", 32'(overflow), 32'd1);

    // T5: address wrap with masked header bits
    drive(1'b1, 32'hABCF_FFFF, 1'b0);
    step();
    drive(1'b1, 32'h5555_0000, 1'b0);
    step();
    check("t5_w0_addr", 32'(imem_addr), 32'hFFFFC);
    drive(1'b1, 32'h5555_0001, 1'b1);
    step();
    check("t5_w1_we", 32'(imem_we), 32'd1);
    check("t5_w1_addr", 32'(imem_addr), 32'h00000);
    check("t5_w1_data", imem_wdata, 32'h5555_0001);
    drive(1'b0, 32'h0, 1'b0);
    wait_start();
    check("t5_prog", 32'(prog_address), 32'hFFFFC);
    step();
    step();
    drive(1'b1, 32'h7777_7777, 1'b0);
    step();
    check("t5_run_ready", 32'(sif.in_ready), 32'd0);
    check("t5_run_no_we", 32'(imem_we), 32'd0);

    // T6: reset mid-RUN, then mid-LOAD, then a clean load
    rst = 1'b1;
    step();
    check_reset_outputs("t6_run");
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    step();
    check("t6_idle_ready", 32'(sif.in_ready), 32'd1);
    drive(1'b1, 32'h0000_0400, 1'b0);
    step();
    drive(1'b1, 32'h6666_0000, 1'b0);
    step();
    check("t6_load_addr", 32'(imem_addr), 32'h400);
    drive(1'b1, 32'h6666_0001, 1'b0);
    rst = 1'b1;
    step();
    check_reset_outputs("t6_load");
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    step();
    check("t6_ready_again", 32'(sif.in_ready), 32'd1);
    drive(1'b1, 32'h0000_0040, 1'b0);
    step();
    drive(1'b1, 32'h8888_0000, 1'b1);
    step();
    check("t6_new_we", 32'(imem_we), 32'd1);
    check("t6_new_addr", 32'(imem_addr), 32'h040);
    check("t6_new_data", imem_wdata, 32'h8888_0000);
    drive(1'b0, 32'h0, 1'b0);
    wait_start();
    check("t6_prog", 32'(prog_address), 32'h040);
    step();
    core_halt = 1'b1;
    step();
    core_halt = 1'b0;
    check("t6_report", 32'(report), 32'd1);
    check("t6_done", 32'(done), 32'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
